// File: rtl/ex13_result_window.sv
// ex13_result_window: collects WINDOW samples into a sum/avg/max/min summary held in a valid/ready output register
module ex13_result_window #(
  parameter int WINDOW = 4,
  parameter int DW = 16,
  parameter int LOGW = 2,
  parameter int SW = DW + LOGW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          clr,
  output logic [SW-1:0] out_sum,
  output logic [DW-1:0] out_avg,
  output logic [DW-1:0] out_max,
  output logic [DW-1:0] out_min,
  output logic          out_valid,
  input  logic          out_ready
);
  logic [LOGW-1:0] cnt;
  logic [SW-1:0] acc_sum, nsum;
  logic [DW-1:0] acc_max, acc_min, nmax, nmin;
  logic first, last, take;
  always_comb begin
    first = cnt == '0;
    last = cnt == LOGW'(WINDOW - 1);
    in_ready = reset & ~(last & out_valid & ~out_ready);
    take = in_valid & in_ready & ~clr;
    nsum = (first ? '0 : acc_sum) + SW'(in_data);
    nmax = (first || in_data > acc_max) ? in_data : acc_max;
    nmin = (first || in_data < acc_min) ? in_data : acc_min;
  end
  // the closing sample of a window also restarts the running registers
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      acc_sum <= '0;
      acc_max <= '0;
      acc_min <= '1;
    end else if (clr || (take && last)) begin
      cnt <= '0;
      acc_sum <= '0;
      acc_max <= '0;
      acc_min <= '1;
    end else if (take) begin
      cnt <= cnt + LOGW'(1);
      acc_sum <= nsum;
      acc_max <= nmax;
      acc_min <= nmin;
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out_sum <= '0;
      out_avg <= '0;
      out_max <= '0;
      out_min <= '0;
      out_valid <= 1'b0;
    end else if (take && last) begin
      out_sum <= nsum;
      out_avg <= nsum[SW-1:LOGW];
      out_max <= nmax;
      out_min <= nmin;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_ex13_result_window.sv
// tb_ex13_result_window: directed scenarios plus a randomized run against a queue-based window model
module tb_ex13_result_window;
  logic clk = 0, reset = 0, in_valid = 0, clr = 0, out_ready = 0;
  logic [15:0] in_data = 0;
  logic in_ready, out_valid;
  logic [17:0] out_sum;
  logic [15:0] out_avg, out_max, out_min;
  int checks = 0, failures = 0;
  logic [15:0] q[$];

  ex13_result_window dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .clr(clr), .out_sum(out_sum), .out_avg(out_avg), .out_max(out_max), .out_min(out_min),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [66:0] summ(input logic [15:0] s[$]);
    logic [17:0] sum = 0;
    logic [15:0] mx = 0, mn = 16'hFFFF;
    foreach (s[i]) begin
      sum += 18'(s[i]);
      if (s[i] > mx) mx = s[i];
      if (s[i] < mn) mn = s[i];
    end
    return {1'b1, sum, 16'(sum / 4), mx, mn};
  endfunction

  function automatic logic [66:0] obs();
    return {out_valid, out_sum, out_avg, out_max, out_min};
  endfunction

  task automatic drive(input logic v, input logic [15:0] d, input logic c);
    in_valid = v;
    in_data = d;
    clr = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (obs() !== 67'd0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got %h rdy=%b, required 0 rdy=0", obs(), in_ready);
    end
    @(negedge clk);
    reset = 1;
    out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b, required 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    q = '{16'h0014, 16'h004A, 16'h00A6, 16'h0150};
    foreach (q[i]) drive(1, q[i], 0);
    checks++;
    if (obs() !== summ(q) || out_sum !== 18'h00254 || out_avg !== 16'h0095) begin
      failures++;
      $display("FAIL basic_summary: got %h, required %h", obs(), summ(q));
    end
    drive(0, 0, 0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_drain: out_valid got %b, required 0", out_valid);
    end
  endtask

  task automatic test_full_scale();
    q = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    foreach (q[i]) drive(1, q[i], 0);
    checks++;
    if (obs() !== summ(q) || out_sum !== 18'h3FFFC) begin
      failures++;
      $display("FAIL full_scale_ones: got %h, required %h", obs(), summ(q));
    end
    q = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    foreach (q[i]) drive(1, q[i], 0);
    checks++;
    if (obs() !== summ(q)) begin
      failures++;
      $display("FAIL full_scale_zeros: got %h, required %h", obs(), summ(q));
    end
    drive(0, 0, 0);
  endtask

  task automatic test_backpressure();
    logic [66:0] ea;
    out_ready = 0;
    q = '{16'd1, 16'd2, 16'd3, 16'd4};
    ea = summ(q);
    foreach (q[i]) drive(1, q[i], 0);
    checks++;
    if (obs() !== ea || out_sum !== 18'h0000A) begin
      failures++;
      $display("FAIL bp_window_a: got %h, required %h", obs(), ea);
    end
    for (int i = 5; i <= 7; i++) begin
      in_valid = 1;
      in_data = 16'(i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL bp_accept_%0d: in_ready got %b, required 1", i, in_ready);
      end
      drive(1, 16'(i), 0);
    end
    in_data = 16'd8;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || obs() !== ea) begin
        failures++;
        $display("FAIL bp_stall_%0d: rdy=%b out=%h, required rdy=0 out=%h", i, in_ready, obs(), ea);
      end
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready: got %b, required 1", in_ready);
    end
    q = '{16'd5, 16'd6, 16'd7, 16'd8};
    drive(1, 16'd8, 0);
    checks++;
    if (obs() !== summ(q) || out_sum !== 18'h0001A) begin
      failures++;
      $display("FAIL bp_window_b: got %h, required %h", obs(), summ(q));
    end
    drive(0, 0, 0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain: out_valid got %b, required 0", out_valid);
    end
  endtask

  task automatic test_gaps();
    logic [6:0] v = 7'b1101001;
    logic [15:0] d[7] = '{16'h10, 16'h0, 16'h0, 16'h20, 16'h0, 16'h30, 16'h40};
    q = '{16'h10, 16'h20, 16'h30, 16'h40};
    for (int i = 0; i < 7; i++) begin
      drive(v[i], d[i], 0);
      if (i == 5) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL gaps_early: out_valid got %b, required 0", out_valid);
        end
      end
    end
    checks++;
    if (obs() !== summ(q) || out_avg !== 16'h0028) begin
      failures++;
      $display("FAIL gaps_summary: got %h, required %h", obs(), summ(q));
    end
    drive(0, 0, 0);
  endtask

  task automatic test_clear();
    drive(1, 16'h0100, 0);
    drive(1, 16'h0200, 0);
    drive(1, 16'h0300, 1);
    q = '{16'h1, 16'h1, 16'h1, 16'h1};
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL clear_early: out_valid got %b, required 0", out_valid);
        end
      end
      drive(1, 16'h1, 0);
    end
    checks++;
    if (obs() !== summ(q) || out_sum !== 18'h00004) begin
      failures++;
      $display("FAIL clear_summary: got %h, required %h", obs(), summ(q));
    end
    drive(0, 0, 0);
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    for (int i = 0; i < 6; i++) drive(1, 16'h9, 0);
    in_valid = 0;
    #2;
    reset = 0;
    #1;
    checks++;
    if (obs() !== 67'd0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: got %h rdy=%b, required 0 rdy=0", obs(), in_ready);
    end
    @(negedge clk);
    reset = 1;
    out_ready = 1;
    q = '{16'h3, 16'h3, 16'h3, 16'h3};
    foreach (q[i]) drive(1, q[i], 0);
    checks++;
    if (obs() !== summ(q) || out_sum !== 18'h0000C) begin
      failures++;
      $display("FAIL reset_mid_fresh: got %h, required %h", obs(), summ(q));
    end
    drive(0, 0, 0);
  endtask

  task automatic test_random();
    logic pend = 0, exp_rdy, load;
    logic [66:0] ps = 0;
    logic [15:0] win[$];
    reset = 0;
    #2;
    reset = 1;
    @(negedge clk);
    for (int n = 0; n < 400; n++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      in_data = 16'($urandom);
      clr = 1'($urandom_range(0, 19) == 0);
      out_ready = 1'($urandom_range(0, 2) == 0);
      exp_rdy = !(win.size() == 3 && pend && !out_ready);
      #1;
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++;
        $display("FAIL rand_ready_%0d: got %b, required %b", n, in_ready, exp_rdy);
      end
      @(posedge clk);
      load = 0;
      if (clr) win.delete();
      else if (in_valid && exp_rdy) begin
        win.push_back(in_data);
        if (win.size() == 4) begin
          load = 1;
          ps = summ(win);
          win.delete();
        end
      end
      if (load) pend = 1;
      else if (out_ready) pend = 0;
      @(negedge clk);
      checks++;
      if (out_valid !== pend || (pend && obs() !== ps)) begin
        failures++;
        $display("FAIL rand_out_%0d: got %h, required valid=%b %h", n, obs(), pend, ps);
      end
    end
    in_valid = 0;
    clr = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_scale();
    test_backpressure();
    test_gaps();
    test_clear();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex13_result_window.md
Name: ex13_result_window

Overview:
Downstream consumer of the EX_13 datapath's 16-bit result stream g. Collects WINDOW consecutive accepted results and produces one window summary: sum, average, maximum and minimum. The summary is presented through a valid/ready output register. Backpressure reaches the producer via in_ready, so no window result is ever lost.

Parameters:
WINDOW, 4, samples per window; power of two, 2..256
DW, 16, input sample width (matches g)
LOGW, 2, log2(WINDOW); must be consistent with WINDOW
SW, DW+LOGW, width of the sum output

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_data  in  DW  sample (g from EX_13)
in_valid  in  1  in_data is valid this cycle
in_ready  out  1  block can accept a sample this cycle
clr  in  1  synchronous clear of the partial window
out_sum  out  SW  sum of the window's samples, unsigned
out_avg  out  DW  out_sum >> LOGW (truncating)
out_max  out  DW  largest sample in the window
out_min  out  DW  smallest sample in the window
out_valid  out  1  summary registers hold an unconsumed result
out_ready  in  1  consumer accepts the summary this cycle

Behaviour:
- Accept event: in_valid & in_ready at a rising edge. Handshake on the output side: out_valid & out_ready at a rising edge.
- Reset (reset=0, asynchronous), while asserted:
  - cnt=0, acc_sum=0, acc_max=0, acc_min=all-ones.
  - out_sum, out_avg, out_max, out_min are all 0; out_valid=0.
  - in_ready is forced to 0.
  - Reset mid-window discards the partial window and any pending summary.
- Internal state:
  - cnt counts 0..WINDOW-1.
  - Running registers acc_sum (SW bits), acc_max and acc_min (DW bits each).
- Accept with cnt<WINDOW-1:
  - acc_sum += in_data; acc_max=max(acc_max,in_data); acc_min=min(acc_min,in_data); cnt++.
  - On the first sample (cnt=0), the running registers load in_data directly instead of combining.
- Accept with cnt=WINDOW-1 (last sample):
  - Outputs load the final values, including this sample: out_sum=acc_sum+in_data, out_avg=that sum>>LOGW, and out_max/out_min.
  - out_valid=1 on the same edge, so the summary appears 1 cycle after the last sample is accepted.
  - cnt returns to 0.
- No overflow is possible: SW = DW+LOGW holds WINDOW × (2^DW − 1) exactly.
- Output register:
  - Holds its value while out_valid=1 and out_ready=0.
  - On an output handshake with no simultaneous load, out_valid goes to 0; data values are retained but don't care.
  - Load and handshake on the same edge: the new summary replaces the old one and out_valid stays 1.
- in_ready = reset & ~(cnt==WINDOW-1 & out_valid & ~out_ready).
  - Samples other than the last of a window are always accepted, even while a summary is pending.
  - The last sample stalls only when the output register is occupied and not draining this cycle.
- in_ready is combinational from out_valid, out_ready and cnt. It has no combinational path from in_valid.
- clr=1 at an edge:
  - cnt=0 and the running registers return to their reset values.
  - Any sample presented on that edge is dropped, even if in_ready=1; clr wins.
  - The pending summary and out_valid are unaffected.
- in_valid=0 leaves all accumulation state unchanged. No timeout applies.
- No state machine beyond cnt plus out_valid.
- Expected RTL size is roughly 150 lines.

Test Plan:
1. Basic window (WINDOW=4), out_ready=1: samples 0x0014, 0x004A, 0x00A6, 0x0150 on consecutive cycles -> one cycle after the 4th accept, out_valid=1 with out_sum=0x00254, out_avg=0x0095, out_max=0x0150, out_min=0x0014; out_valid=0 on the next cycle.
2. Full-scale: four samples of 0xFFFF -> out_sum=0x3FFFC, out_avg=0xFFFF, max=min=0xFFFF. Then four samples of 0x0000 -> out_sum=0, min=0; this confirms the min register is reloaded per window.
3. Backpressure, out_ready=0: complete window A (1,2,3,4 -> sum 0x0000A); feed window B samples 5, 6, 7, which are all accepted.
   - 4th sample 8 -> in_ready=0 and the stall holds; window A outputs remain stable.
   - Raise out_ready -> A is consumed and 8 is accepted on the same edge; next cycle B: sum=0x0001A, max=8, min=5.
4. Gaps: in_valid toggled 1,0,0,1,0,1,1 carrying 0x0010, -, -, 0x0020, -, 0x0030, 0x0040 -> single summary with sum=0x000A0, avg=0x0028.
5. Clear: accept 0x0100 and 0x0200, then assert clr together with in_valid on 0x0300 -> 0x0300 dropped. Next four samples of 0x0001 -> sum=0x00004; no trace of 0x0100 or 0x0200.
6. Reset mid-operation: out_valid=1 pending plus 2 samples in a partial window; pulse reset low between clock edges -> all outputs 0 and in_ready=0 immediately. After release, a fresh window of 0x0003 ×4 -> sum=0x0000C.
